// File: rtl/usb_uart_arb_pkg.sv
// ============================================================================
// usb_uart_arb_pkg : shared types and width helpers for the USB IN arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package usb_uart_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int BYTE_W = 8;

    // Owner index width; a single source still needs one bit to carry an index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_uart_in_arb_if.sv
// ============================================================================
// usb_uart_in_arb_if : source-side and host-side byte handshakes of the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface usb_uart_in_arb_if
    import usb_uart_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
);
    localparam int OWN_W = idx_w(NUM_SRC);

    logic [BYTE_W*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC-1:0]        src_ready;
    logic [BYTE_W-1:0]         uart_in_data;
    logic                      uart_in_valid;
    logic                      uart_in_ready;
    logic [OWN_W-1:0]          grant_id;
    logic                      busy;

    modport master (
        output src_data, src_valid, src_last, uart_in_ready,
        input  src_ready, uart_in_data, uart_in_valid, grant_id, busy
    );

    modport slave (
        input  src_data, src_valid, src_last, uart_in_ready,
        output src_ready, uart_in_data, uart_in_valid, grant_id, busy
    );

endinterface

`default_nettype wire

// File: rtl/usb_rr_pick.sv
// ============================================================================
// usb_rr_pick : rotate-priority encoder, first request strictly after ptr_i
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_rr_pick
    import usb_uart_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int OWN_W  = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [OWN_W-1:0]   ptr_i,
    output logic [OWN_W-1:0]   idx_o,
    output logic               any_o
);

    logic [OWN_W-1:0] w_cand;

    // Walk ptr+1 .. ptr+NUM_SRC so the previous owner is considered last.
    always_comb begin
        idx_o  = '0;
        any_o  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = OWN_W'((int'(ptr_i) + k) % NUM_SRC);
            if (!any_o && req_i[w_cand]) begin
                any_o = 1'b1;
                idx_o = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/usb_uart_in_arb.sv
// ============================================================================
// usb_uart_in_arb : message-granular round-robin arbiter onto the USB IN pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_uart_in_arb
    import usb_uart_arb_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    usb_uart_in_arb_if.slave bus
);

    localparam int OWN_W   = idx_w(NUM_SRC);
    localparam int BURST_W = cnt_w(MAX_BURST);
    localparam int IDLE_W  = cnt_w(IDLE_TIMEOUT);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [OWN_W-1:0]   PTR_RESET  = OWN_W'(NUM_SRC - 1);

    arb_state_e           state_q, state_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;

    logic [BYTE_W-1:0]    w_bytes [NUM_SRC];
    logic [OWN_W-1:0]     w_pick;
    logic                 w_any;
    logic                 w_active;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_release;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
            assign w_bytes[i] = bus.src_data[BYTE_W*i +: BYTE_W];
        end
    endgenerate

    usb_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req_i   (bus.src_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (w_pick),
        .any_o   (w_any)
    );

    // Reset gates the pass-through so an aborted grant cannot complete a byte.
    assign w_active    = (state_q == ST_GRANT) && !reset;
    assign w_own_valid = bus.src_valid[owner_q];
    assign w_own_last  = bus.src_last[owner_q];
    assign w_valid     = w_active && w_own_valid;
    assign w_xfer      = w_valid && bus.uart_in_ready;

    assign bus.uart_in_valid = w_valid;
    assign bus.uart_in_data  = w_active ? w_bytes[owner_q] : '0;
    assign bus.busy          = w_active;
    assign bus.grant_id      = owner_q;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_ready
            assign bus.src_ready[i] = w_active && (owner_q == OWN_W'(i)) && bus.uart_in_ready;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        w_release   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    owner_d = w_pick;
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                w_release = (w_xfer && w_own_last)
                         || (w_xfer && (burst_cnt_q == BURST_LAST))
                         || (!w_own_valid && (idle_cnt_q == IDLE_LAST));
                if (w_release) begin
                    state_d     = ST_IDLE;
                    rr_ptr_d    = owner_q;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end else if (w_xfer) begin
                    burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
                    idle_cnt_d  = '0;
                end else if (!w_own_valid) begin
                    // Host backpressure holds the count; only a silent owner ages.
                    idle_cnt_d  = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= PTR_RESET;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_uart_in_arb.sv
// ============================================================================
// tb_usb_uart_in_arb : directed self-checking bench for usb_uart_in_arb
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_usb_uart_in_arb;

    logic clk;
    logic reset;

    usb_uart_in_arb_if #(.NUM_SRC(4)) bus ();

    usb_uart_in_arb #(
        .NUM_SRC      (4),
        .MAX_BURST    (64),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_fail;
    int n_total;

    // Source byte-stream model: per-source buffer, length, read position.
    logic [7:0] mem   [4][128];
    logic       lastf [4][128];
    int         len   [4];
    int         pos   [4];
    int         n_acc [4];
    logic       tb_ready;

    logic       cap_busy;
    logic       cap_valid;
    logic [7:0] cap_data;
    logic [3:0] cap_ready;
    logic [1:0] cap_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: no last flag, 1: last on final byte, 2: every byte is a message
    task automatic load(input int i, input int n, input logic [7:0] base, input int mode);
        for (int k = 0; k < 128; k++) begin
            mem[i][k]   = base + 8'(k);
            lastf[i][k] = (mode == 2) || ((mode == 1) && (k == n - 1));
        end
        len[i] = n;
        pos[i] = 0;
    endtask

    task automatic drive();
        logic [31:0] d;
        logic [3:0]  v;
        logic [3:0]  l;
        d = '0;
        v = '0;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            if (pos[i] < len[i]) begin
                v[i]         = 1'b1;
                d[8*i +: 8]  = mem[i][pos[i]];
                l[i]         = lastf[i][pos[i]];
            end
        end
        bus.src_data      = d;
        bus.src_valid     = v;
        bus.src_last      = l;
        bus.uart_in_ready = tb_ready;
    endtask

    // One clock: drive, capture mid-cycle, advance past the edge, retire accepted bytes.
    task automatic step();
        drive();
        #1;
        cap_busy  = bus.busy;
        cap_valid = bus.uart_in_valid;
        cap_data  = bus.uart_in_data;
        cap_ready = bus.src_ready;
        cap_grant = bus.grant_id;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (cap_ready[i]) begin
                pos[i]++;
                n_acc[i]++;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) begin
            len[i]   = 0;
            pos[i]   = 0;
            n_acc[i] = 0;
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [7:0] exp_t2 [5];

    initial begin
        n_pass   = 0;
        n_fail   = 0;
        n_total  = 0;
        tb_ready = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            len[i]   = 0;
            pos[i]   = 0;
            n_acc[i] = 0;
        end

        // Reset state
        do_reset();
        chk("rst busy",  cap_busy,  0);
        chk("rst valid", cap_valid, 0);
        chk("rst data",  cap_data,  0);
        chk("rst ready", cap_ready, 0);
        chk("rst grant", cap_grant, 0);

        // Test 1: three-byte message from src0
        load(0, 3, 8'h41, 1);
        step();
        chk("t1 arb busy",  cap_busy,  0);
        chk("t1 arb valid", cap_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1 busy",  cap_busy,  1);
            chk("t1 valid", cap_valid, 1);
            chk("t1 data",  cap_data,  32'h41 + k);
            chk("t1 ready", cap_ready, 4'b0001);
            chk("t1 grant", cap_grant, 0);
        end
        step();
        chk("t1 post busy",  cap_busy,  0);
        chk("t1 post valid", cap_valid, 0);
        chk("t1 post grant", cap_grant, 0);

        // Test 2: all sources continuously offering 1-byte messages
        do_reset();
        for (int i = 0; i < 4; i++) load(i, 5, 8'(16 * i), 2);
        exp_t2[0] = 8'h00;
        exp_t2[1] = 8'h10;
        exp_t2[2] = 8'h20;
        exp_t2[3] = 8'h30;
        exp_t2[4] = 8'h01;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t2 idle busy", cap_busy, 0);
            step();
            chk("t2 busy",  cap_busy,  1);
            chk("t2 grant", cap_grant, g % 4);
            chk("t2 data",  cap_data,  exp_t2[g]);
            chk("t2 ready", cap_ready, 4'b0001 << (g % 4));
        end

        // Test 3: 100-byte stream with no last, capped at 64 per grant
        do_reset();
        load(1, 100, 8'h00, 0);
        step();
        chk("t3 arb busy", cap_busy, 0);
        for (int k = 0; k < 64; k++) begin
            step();
            chk("t3 data a", cap_data,  k);
            chk("t3 grant a", cap_grant, 1);
        end
        step();
        chk("t3 cap release busy", cap_busy, 0);
        for (int k = 64; k < 100; k++) begin
            step();
            chk("t3 data b",  cap_data,  k);
            chk("t3 valid b", cap_valid, 1);
        end
        chk("t3 accepted", n_acc[1], 100);

        // Test 4: owner goes quiet after 2 bytes; timeout then src3
        do_reset();
        load(2, 2, 8'hA0, 0);
        load(3, 1, 8'hB0, 1);
        step();
        chk("t4 arb busy", cap_busy, 0);
        step();
        chk("t4 grant", cap_grant, 2);
        chk("t4 b0",    cap_data,  8'hA0);
        step();
        chk("t4 b1",    cap_data,  8'hA1);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("t4 hold busy",  cap_busy,  1);
            chk("t4 hold valid", cap_valid, 0);
        end
        step();
        chk("t4 release busy", cap_busy,  0);
        chk("t4 release grant", cap_grant, 2);
        step();
        chk("t4 src3 busy",  cap_busy,  1);
        chk("t4 src3 grant", cap_grant, 3);
        chk("t4 src3 data",  cap_data,  8'hB0);

        // Test 5: long host backpressure
        do_reset();
        tb_ready = 1'b0;
        load(0, 1, 8'h5A, 1);
        step();
        for (int k = 0; k < 200; k++) begin
            step();
            chk("t5 stall busy",  cap_busy,  1);
            chk("t5 stall valid", cap_valid, 1);
            chk("t5 stall data",  cap_data,  8'h5A);
            chk("t5 stall ready", cap_ready, 0);
        end
        tb_ready = 1'b1;
        step();
        chk("t5 go ready", cap_ready, 4'b0001);
        step();
        chk("t5 done busy",  cap_busy,  0);
        chk("t5 done valid", cap_valid, 0);
        chk("t5 once",       n_acc[0],  1);

        // Test 6: reset mid-burst of src2 after a completed src0 message
        do_reset();
        load(0, 1, 8'h11, 1);
        load(2, 20, 8'h80, 0);
        step();
        step();
        chk("t6 src0 data", cap_data, 8'h11);
        step();
        chk("t6 arb busy", cap_busy, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t6 src2 grant", cap_grant, 2);
            chk("t6 src2 data",  cap_data,  8'h80 + k);
        end
        load(0, 1, 8'h22, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6 rst valid", cap_valid, 0);
        chk("t6 rst ready", cap_ready, 0);
        step();
        chk("t6 post busy",  cap_busy,  0);
        chk("t6 post valid", cap_valid, 0);
        chk("t6 post data",  cap_data,  0);
        chk("t6 post ready", cap_ready, 0);
        chk("t6 post grant", cap_grant, 0);
        step();
        chk("t6 regrant id",   cap_grant, 0);
        chk("t6 regrant data", cap_data,  8'h22);
        step();
        step();
        chk("t6 resume grant", cap_grant, 2);
        chk("t6 resume data",  cap_data,  8'h8A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
